fifo_xfer_ctrl: RTL and testbench
=================================

Name: fifo_xfer_ctrl

Overview:
Block-transfer sequencer between the ADMA engine and the 32-deep word FIFO (31 usable entries). It moves a programmed number of 32-bit words in one direction per command: ADMA->FIFO (write) or FIFO->ADMA (read). It drives the FIFO read/write strobes so the FIFO is never written when full or read when empty, and it counts words, detects stalls and reports completion.

Parameters:
CNT_W, 10, width of word count; max block = 2^CNT_W-1 words
TIMEOUT, 1023, consecutive no-progress cycles in a transfer state before error

Ports:
CLK  in  1  clock, all state updates on posedge
RESET  in  1  synchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
dir  in  1  0 = ADMA->FIFO write, 1 = FIFO->ADMA read; latched on start
blk_words  in  CNT_W  word count; latched on start
abort  in  1  cancel current transfer
dma_wdata  in  32  write-direction data from ADMA
dma_wvalid  in  1  write data valid
dma_wready  out  1  controller accepts dma_wdata this cycle
dma_rdata  out  32  read-direction data to ADMA, wired from fifo_data_out
dma_rvalid  out  1  dma_rdata valid
dma_rready  in  1  ADMA consumes dma_rdata
fifo_data_in  out  32  to FIFO data_in, wired from dma_wdata
fifo_data_out  in  32  from FIFO data_out, registered on read edge
fifo_write  out  1  FIFO write strobe
fifo_read  out  1  FIFO read strobe
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
busy  out  1  high in WR, RD and DRAIN
done  out  1  one-cycle pulse on normal completion
error  out  1  one-cycle pulse on timeout
word_cnt  out  CNT_W  words transferred in the current/last command

Behaviour:
- Clock port CLK; reset port RESET, synchronous, active-high. Reset forces IDLE and clears the internal stall and issue counters. Reset values: busy=0, done=0, error=0, dma_rvalid=0, word_cnt=0. Combinational strobes fifo_write, fifo_read and dma_wready evaluate to 0 in IDLE. FIFO contents are not flushed.
- States: IDLE, WR, RD, DRAIN, FIN, ERR.
- IDLE:
  - start=1: latch dir and blk_words, clear word_cnt and the stall counter.
  - blk_words=0 -> FIN with no FIFO access.
  - Otherwise dir=0 -> WR; dir=1 -> RD.
  - start while not IDLE is ignored.
- WR:
  - dma_wready = !fifo_full.
  - fifo_write = dma_wvalid & !fifo_full, combinational, same cycle.
  - Each fifo_write increments word_cnt. The write that makes word_cnt == blk_words -> FIN.
- RD:
  - fifo_read = !fifo_empty & (issued < blk_words) & (!dma_rvalid | dma_rready).
  - dma_rvalid is a register: set on the cycle after fifo_read; cleared when dma_rready=1 and no new read is issued.
  - dma_rdata holds the FIFO output register value until the next read.
  - word_cnt increments on each dma_rvalid & dma_rready handshake.
  - When issued == blk_words -> DRAIN.
- DRAIN: wait for the final handshake (word_cnt == blk_words) -> FIN. fifo_read = 0.
- FIN: done=1 for one cycle -> IDLE. word_cnt holds its value until the next start.
- Stall counter:
  - Active in WR, RD and DRAIN. Increments on each cycle with no fifo_write, fifo_read or read handshake; clears on progress.
  - Reaching TIMEOUT -> ERR. ERR: error=1 for one cycle -> IDLE, dma_rvalid cleared.
- abort=1 in any non-IDLE state:
  - Next state IDLE, dma_rvalid cleared, no done and no error.
  - Strobes are gated to 0 in the abort cycle.
  - abort has priority over completion in the same cycle.
- RESET has priority over abort and start. Reset mid-transfer returns to IDLE immediately.
- Counters are CNT_W bits and never wrap, since completion is reached first.
- Latency:
  - Write: 0 cycles from dma_wvalid to fifo_write.
  - Read: 1 cycle from fifo_read to dma_rvalid.
  - Sustained throughput is 1 word/cycle in both directions when the FIFO and ADMA are not stalling.

Test Plan:
- Reset, then start dir=0, blk_words=8, dma_wvalid held high, words 0x100..0x107 -> 8 consecutive fifo_write, FIFO holds 0x100..0x107, done pulses 1 cycle after the 8th write, word_cnt=8.
- Write 40 words into an empty FIFO that is never read -> exactly 31 fifo_write, dma_wready low while full; after 1023 stalled cycles error pulses, state IDLE, done never asserted.
- FIFO preloaded with 0xA0..0xA4, start dir=1, blk_words=5, dma_rready=1 -> fifo_read for 5 consecutive cycles, dma_rvalid one cycle later, dma_rdata=0xA0..0xA4 in order, done after the last handshake, no read while empty.
- Read with dma_rready toggling 1,0,0,1,... -> dma_rdata stable while dma_rvalid & !dma_rready, no extra fifo_read, all 5 words delivered exactly once.
- start with blk_words=0 -> done on the next cycle, no strobes; a start asserted while busy is ignored (word_cnt unaffected).
- abort after 3 of 8 writes, and separately RESET after 2 of 5 reads -> IDLE next cycle, no done/error, strobes low, a subsequent command completes normally.

Source files
------------

// File: rtl/fifo_xfer_ctrl_if.sv
// ADMA/FIFO data-path bundle for the block-transfer sequencer.
// master = sequencer side, slave = ADMA engine plus FIFO side.
interface fifo_xfer_ctrl_if;
    logic [31:0] dma_wdata;
    logic        dma_wvalid;
    logic        dma_wready;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        dma_rready;
    logic [31:0] fifo_data_in;
    logic [31:0] fifo_data_out;
    logic        fifo_write;
    logic        fifo_read;
    logic        fifo_full;
    logic        fifo_empty;

    modport master (
        input  dma_wdata, dma_wvalid, dma_rready,
        input  fifo_data_out, fifo_full, fifo_empty,
        output dma_wready, dma_rdata, dma_rvalid,
        output fifo_data_in, fifo_write, fifo_read
    );

    modport slave (
        output dma_wdata, dma_wvalid, dma_rready,
        output fifo_data_out, fifo_full, fifo_empty,
        input  dma_wready, dma_rdata, dma_rvalid,
        input  fifo_data_in, fifo_write, fifo_read
    );
endinterface

// File: rtl/fifo_xfer_ctrl.sv
// Block-transfer sequencer moving a counted number of words between
// the ADMA engine and the word FIFO, with stall timeout and abort.
module fifo_xfer_ctrl #(
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] blk_words,
    input  logic             abort,
    fifo_xfer_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int ST_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN, ERR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] iss_q, iss_d;
    logic [ST_W-1:0]  stall_q, stall_d;
    logic             rvalid_q, rvalid_d;
    logic             live, xfer, wready, wr_fire, rd_fire, rd_hs;

    always_comb begin
        // strobes are killed by abort and by reset in the same cycle
        live    = !RESET && !abort;
        xfer    = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);
        wready  = live && (state_q == WR) && !bus.fifo_full;
        wr_fire = wready && bus.dma_wvalid;
        rd_fire = live && (state_q == RD) && !bus.fifo_empty &&
                  (iss_q < blk_q) && (!rvalid_q || bus.dma_rready);
        rd_hs   = live && rvalid_q && bus.dma_rready;

        state_d  = state_q;
        blk_d    = blk_q;
        cnt_d    = cnt_q;
        iss_d    = iss_q;
        stall_d  = stall_q;
        rvalid_d = rvalid_q;

        if (wr_fire || rd_hs) cnt_d = cnt_q + 1'b1;
        if (rd_fire) iss_d = iss_q + 1'b1;

        if (rd_fire) rvalid_d = 1'b1;
        else if (rd_hs) rvalid_d = 1'b0;

        if (xfer) begin
            if (wr_fire || rd_fire || rd_hs) stall_d = '0;
            else stall_d = stall_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    blk_d   = blk_words;
                    cnt_d   = '0;
                    iss_d   = '0;
                    stall_d = '0;
                    if (blk_words == '0) state_d = FIN;
                    else if (dir) state_d = RD;
                    else state_d = WR;
                end
            end
            WR:    if (wr_fire && cnt_d == blk_q) state_d = FIN;
            RD:    if (iss_d == blk_q) state_d = DRAIN;
            DRAIN: if (cnt_d == blk_q) state_d = FIN;
            FIN:   state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (xfer && stall_d == ST_W'(TIMEOUT)) state_d = ERR;
        if (abort && state_q != IDLE) state_d = IDLE;

        if (!(state_d == RD || state_d == DRAIN)) rvalid_d = 1'b0;
        if (!(state_d == WR || state_d == RD || state_d == DRAIN)) stall_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            cnt_q    <= '0;
            iss_q    <= '0;
            stall_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            cnt_q    <= cnt_d;
            iss_q    <= iss_d;
            stall_q  <= stall_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.dma_wready   = wready;
    assign bus.fifo_write   = wr_fire;
    assign bus.fifo_read    = rd_fire;
    assign bus.dma_rvalid   = rvalid_q;
    assign bus.dma_rdata    = bus.fifo_data_out;
    assign bus.fifo_data_in = bus.dma_wdata;

    assign busy     = xfer;
    assign done     = (state_q == FIN);
    assign error    = (state_q == ERR);
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_xfer_ctrl.sv
// Directed bench for fifo_xfer_ctrl with a 32-deep FIFO model
// (31 usable entries) and an ADMA-side handshake monitor.
module tb_fifo_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, dir, abort;
    logic [9:0] blk;
    logic       busy, done, error;
    logic [9:0] word_cnt;

    fifo_xfer_ctrl_if b ();

    fifo_xfer_ctrl dut (
        .CLK       (clk),
        .RESET     (rst),
        .start     (start),
        .dir       (dir),
        .blk_words (blk),
        .abort     (abort),
        .bus       (b),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: registered output, flags from occupancy
    logic [31:0] mem [32];
    logic [4:0]  wp, rp;
    logic [5:0]  occ;
    logic [31:0] dout;
    logic        fl, pl;
    logic [31:0] pl_data;
    logic        wok, rok;

    assign b.fifo_full     = (occ == 6'd31);
    assign b.fifo_empty    = (occ == 6'd0);
    assign b.fifo_data_out = dout;
    assign wok = b.fifo_write && !b.fifo_full;
    assign rok = b.fifo_read && !b.fifo_empty;

    always @(posedge clk) begin
        if (fl) begin
            wp <= '0; rp <= '0; occ <= '0;
        end else if (pl) begin
            mem[wp] <= pl_data; wp <= wp + 1'b1; occ <= occ + 1'b1;
        end else begin
            if (wok) begin mem[wp] <= b.fifo_data_in; wp <= wp + 1'b1; end
            if (rok) begin dout <= mem[rp]; rp <= rp + 1'b1; end
            occ <= occ + 6'(wok) - 6'(rok);
        end
    end

    // Monitor
    int cyc = 0;
    logic clr;
    int wr_n, rd_n, done_n, err_n, viol, lat_bad, unstable, extra;
    int first_wr, last_wr, first_rd, last_rd, err_cyc;
    logic prev_rd, hold;
    logic [31:0] hold_d;
    logic [31:0] dq [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            wr_n <= 0; rd_n <= 0; done_n <= 0; err_n <= 0; viol <= 0;
            lat_bad <= 0; unstable <= 0; extra <= 0;
            first_wr <= 0; last_wr <= 0; first_rd <= 0; last_rd <= 0;
            err_cyc <= 0; prev_rd <= 0; hold <= 0;
            dq.delete();
        end else begin
            if (b.fifo_write) begin
                if (wr_n == 0) first_wr <= cyc;
                last_wr <= cyc;
                wr_n <= wr_n + 1;
                if (b.fifo_full) viol <= viol + 1;
            end
            if (b.fifo_read) begin
                if (rd_n == 0) first_rd <= cyc;
                last_rd <= cyc;
                rd_n <= rd_n + 1;
                if (b.fifo_empty) viol <= viol + 1;
            end
            prev_rd <= b.fifo_read;
            if (prev_rd && !b.dma_rvalid) lat_bad <= lat_bad + 1;
            if (b.dma_rvalid && b.dma_rready) dq.push_back(b.dma_rdata);
            if (hold && b.dma_rvalid && b.dma_rdata != hold_d)
                unstable <= unstable + 1;
            hold   <= b.dma_rvalid && !b.dma_rready;
            hold_d <= b.dma_rdata;
            if (b.dma_rvalid && !b.dma_rready && b.fifo_read)
                extra <= extra + 1;
            if (done) done_n <= done_n + 1;
            if (error) begin err_n <= err_n + 1; err_cyc <= cyc; end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_stats();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic flush();
        @(negedge clk); fl = 1'b1;
        @(negedge clk); fl = 1'b0;
    endtask

    task automatic preload(logic [31:0] base, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); pl = 1'b1; pl_data = base + 32'(i);
        end
        @(negedge clk); pl = 1'b0;
    endtask

    task automatic cmd(logic d, int n);
        @(negedge clk); start = 1'b1; dir = d; blk = 10'(n);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic push_words(int n, logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); b.dma_wvalid = 1'b1; b.dma_wdata = base + 32'(i);
        end
        @(negedge clk); b.dma_wvalid = 1'b0;
    endtask

    task automatic wait_done(string tag, int bound);
        for (int k = 0; k < bound && done_n == 0 && err_n == 0; k++)
            @(negedge clk);
        check(tag, 32'(done_n != 0 || err_n != 0), 1);
    endtask

    task automatic check_dq(string tag, logic [31:0] base, int n);
        check({tag, "_n"}, 32'(dq.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_d%0d", tag, i),
                  (i < dq.size()) ? dq[i] : 32'hxxxxxxxx, base + 32'(i));
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 0; dir = 0; blk = '0; abort = 0;
        b.dma_wdata = '0; b.dma_wvalid = 1'b1; b.dma_rready = 1'b1;
        fl = 1'b1; pl = 1'b0; pl_data = '0; clr = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(error), 0);
        check("rst_rvalid", 32'(b.dma_rvalid), 0);
        check("rst_wcnt", 32'(word_cnt), 0);
        check("rst_strobes", {29'd0, b.fifo_write, b.fifo_read, b.dma_wready}, 0);
        @(negedge clk);
        rst = 1'b0; fl = 1'b0; clr = 1'b0; b.dma_wvalid = 1'b0;
        b.dma_rready = 1'b0;
        #1 check("idle_strobes", {30'd0, b.fifo_write, b.fifo_read}, 0);

        // write 8 words back to back
        clr_stats();
        cmd(0, 8);
        push_words(8, 32'h100);
        #1;
        check("t1_done", 32'(done), 1);
        check("t1_wcnt", 32'(word_cnt), 8);
        check("t1_wr_n", 32'(wr_n), 8);
        check("t1_b2b", 32'(last_wr - first_wr), 7);
        bad = 0;
        for (int i = 0; i < 8; i++) if (mem[i] !== 32'h100 + 32'(i)) bad++;
        check("t1_mem", 32'(bad), 0);
        @(negedge clk); #1;
        check("t1_done_pulse", 32'(done), 0);
        check("t1_busy", 32'(busy), 0);

        // overfill: 31 writes then timeout
        flush(); clr_stats();
        cmd(0, 40);
        b.dma_wvalid = 1'b1;
        bad = 0;
        for (int k = 0; k < 1500 && err_n == 0; k++) begin
            @(negedge clk);
            b.dma_wdata = 32'h200 + 32'(wr_n);
            #1 if (b.fifo_full && b.dma_wready) bad++;
        end
        b.dma_wvalid = 1'b0;
        check("t2_err_n", 32'(err_n), 1);
        check("t2_wr_n", 32'(wr_n), 31);
        check("t2_wready_full", 32'(bad), 0);
        check("t2_viol", 32'(viol), 0);
        check("t2_tmo", 32'(err_cyc - last_wr), 1024);
        check("t2_done_n", 32'(done_n), 0);
        check("t2_wcnt", 32'(word_cnt), 31);
        check("t2_idle", {30'd0, busy, error}, 0);

        // read 5 with ADMA always ready
        flush(); preload(32'hA0, 5); clr_stats();
        b.dma_rready = 1'b1;
        cmd(1, 5);
        wait_done("t3_term", 50);
        repeat (2) @(negedge clk);
        check("t3_rd_n", 32'(rd_n), 5);
        check("t3_b2b", 32'(last_rd - first_rd), 4);
        check("t3_lat", 32'(lat_bad), 0);
        check("t3_viol", 32'(viol), 0);
        check("t3_done_n", 32'(done_n), 1);
        check("t3_wcnt", 32'(word_cnt), 5);
        check_dq("t3", 32'hA0, 5);

        // read 5 with ADMA backpressure 1,0,0,...
        flush(); preload(32'hA0, 5); clr_stats();
        b.dma_rready = 1'b0;
        cmd(1, 5);
        for (int k = 0; k < 80 && done_n == 0; k++) begin
            b.dma_rready = (k % 3 == 0);
            @(negedge clk);
        end
        b.dma_rready = 1'b0;
        check("t4_done_n", 32'(done_n), 1);
        check("t4_rd_n", 32'(rd_n), 5);
        check("t4_stable", 32'(unstable), 0);
        check("t4_extra", 32'(extra), 0);
        check("t4_lat", 32'(lat_bad), 0);
        check_dq("t4", 32'hA0, 5);

        // zero-length command
        flush(); clr_stats();
        cmd(0, 0);
        #1;
        check("t5_done", 32'(done), 1);
        check("t5_busy", 32'(busy), 0);
        @(negedge clk);
        check("t5_no_strobe", 32'(wr_n + rd_n), 0);
        check("t5_wcnt", 32'(word_cnt), 0);

        // start while busy is ignored
        clr_stats();
        cmd(0, 4);
        push_words(2, 32'h300);
        start = 1'b1; dir = 1'b1; blk = '0;
        @(negedge clk); start = 1'b0;
        #1;
        check("t5_ign_busy", 32'(busy), 1);
        check("t5_ign_wcnt", 32'(word_cnt), 2);
        push_words(2, 32'h302);
        #1;
        check("t5_ign_done", 32'(done), 1);
        check("t5_ign_cnt", 32'(word_cnt), 4);

        // abort after 3 of 8 writes
        flush(); clr_stats();
        cmd(0, 8);
        push_words(3, 32'h400);
        b.dma_wvalid = 1'b1; abort = 1'b1;
        #1;
        check("t6_gate", {30'd0, b.fifo_write, b.dma_wready}, 0);
        @(negedge clk); abort = 1'b0; b.dma_wvalid = 1'b0;
        #1 check("t6_idle", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("t6_wr_n", 32'(wr_n), 3);
        check("t6_no_fin", 32'(done_n + err_n), 0);
        clr_stats();
        cmd(0, 2);
        push_words(2, 32'h500);
        #1 check("t6_next", {22'd0, word_cnt}, 32'h2);
        @(negedge clk);
        check("t6_next_done", 32'(done_n), 1);

        // reset after 2 of 5 reads
        flush(); preload(32'hA0, 5); clr_stats();
        b.dma_rready = 1'b1;
        cmd(1, 5);
        for (int k = 0; k < 20 && rd_n < 2; k++) @(negedge clk);
        check("t7_two", 32'(rd_n), 2);
        rst = 1'b1;
        #1 check("t7_gate", 32'(b.fifo_read), 0);
        @(negedge clk); rst = 1'b0;
        #1;
        check("t7_idle", {29'd0, busy, b.dma_rvalid, b.fifo_read}, 0);
        check("t7_wcnt", 32'(word_cnt), 0);
        check("t7_rd_n", 32'(rd_n), 2);
        check("t7_no_fin", 32'(done_n + err_n), 0);
        clr_stats();
        cmd(1, 3);
        wait_done("t7_term", 40);
        check("t7_done_n", 32'(done_n), 1);
        check_dq("t7", 32'hA2, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
